cross_bar_arbiter_mux: RTL and testbench

Packet-level round-robin arbiter and multiplexer for one crossbar output port. It merges CHANNEL_NO AXI-Stream inputs, one per source-side demux buffer, onto a single output stream. A grant is held for a whole packet, from the first beat through tlast, so packets never interleave. A registered skid stage on the output decouples timing from the downstream sink.

---
 rtl/cross_bar_arbiter_mux.sv | 170 +++++++++++++++++
 tb/tb_cross_bar_arbiter_mux.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cross_bar_arbiter_mux.sv
// Packet-level round-robin arbiter and multiplexer for one crossbar output port.
// A grant is held from the first beat through tlast; output leaves a 2-entry register slice.
module cross_bar_arbiter_mux #(
    parameter int MSEL_WIDTH = 2,
    parameter int CHANNEL_NO = 2**MSEL_WIDTH,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata  [CHANNEL_NO],
    input  logic                  s_axis_tvalid [CHANNEL_NO],
    input  logic                  s_axis_tlast  [CHANNEL_NO],
    output logic                  s_axis_tready [CHANNEL_NO],
    input  logic [CHANNEL_NO-1:0] port_en,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [MSEL_WIDTH-1:0] grant_bin,
    output logic                  busy
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                r_state, w_state_nxt;
    logic [MSEL_WIDTH-1:0] r_rr_ptr, w_rr_nxt;
    logic [MSEL_WIDTH-1:0] r_grant_bin, w_grant_nxt;

    logic                  w_hi_found, w_lo_found;
    logic [MSEL_WIDTH-1:0] w_hi_idx, w_lo_idx, w_winner;

    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_valid, w_sel_last;
    logic                  w_push, w_pop, w_not_full;

    logic                  r_valid0, r_valid1, r_last0, r_last1;
    logic [DATA_WIDTH-1:0] r_data0, r_data1;

    // Descending scan: the last hit is the lowest index, both at/above rr_ptr and overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int unsigned i = CHANNEL_NO; i > 0; i--) begin
            if (s_axis_tvalid[i-1] && port_en[i-1]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = MSEL_WIDTH'(i - 1);
                if ((i - 1) >= 32'(r_rr_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = MSEL_WIDTH'(i - 1);
                end
            end
        end
        w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int unsigned i = 0; i < CHANNEL_NO; i++) begin
            if (r_grant_bin == MSEL_WIDTH'(i)) begin
                w_sel_data  = s_axis_tdata[i];
                w_sel_valid = s_axis_tvalid[i];
                w_sel_last  = s_axis_tlast[i];
            end
        end
    end

    assign w_pop      = r_valid0 && m_axis_tready;
    assign w_not_full = !r_valid1 || w_pop;
    assign w_push     = (r_state == ACTIVE) && w_sel_valid && w_not_full;

    always_comb begin
        for (int unsigned i = 0; i < CHANNEL_NO; i++) begin
            s_axis_tready[i] = !areset && (r_state == ACTIVE) &&
                               (r_grant_bin == MSEL_WIDTH'(i)) && w_not_full;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_bin;
        w_rr_nxt    = r_rr_ptr;
        unique case (r_state)
            IDLE: begin
                if (w_lo_found) begin
                    w_state_nxt = ACTIVE;
                    w_grant_nxt = w_winner;
                end
            end
            ACTIVE: begin
                if (w_push && w_sel_last) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_rr_nxt    = (r_grant_bin == MSEL_WIDTH'(CHANNEL_NO - 1)) ?
                                  '0 : r_grant_bin + MSEL_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_bin <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_grant_bin <= w_grant_nxt;
        end
    end

    // Entry 0 drives the output; entry 1 only fills while entry 0 is stalled.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
            r_last0  <= 1'b0;
            r_last1  <= 1'b0;
            r_data0  <= '0;
            r_data1  <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_valid0) begin
                        r_valid1 <= 1'b1;
                        r_data1  <= w_sel_data;
                        r_last1  <= w_sel_last;
                    end else begin
                        r_valid0 <= 1'b1;
                        r_data0  <= w_sel_data;
                        r_last0  <= w_sel_last;
                    end
                end
                2'b01: begin
                    if (r_valid1) begin
                        r_data0  <= r_data1;
                        r_last0  <= r_last1;
                        r_valid1 <= 1'b0;
                    end else begin
                        r_valid0 <= 1'b0;
                    end
                end
                2'b11: begin
                    if (r_valid1) begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= w_sel_data;
                        r_last1 <= w_sel_last;
                    end else begin
                        r_data0 <= w_sel_data;
                        r_last0 <= w_sel_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tdata  = r_data0;
    assign m_axis_tvalid = r_valid0;
    assign m_axis_tlast  = r_last0;
    assign grant_bin     = r_grant_bin;
    assign busy          = (r_state == ACTIVE);

endmodule

// File: tb/tb_cross_bar_arbiter_mux.sv
// Scoreboard bench for cross_bar_arbiter_mux: a queue-based reference model predicts
// grants, input readiness and the output beat stream; a monitor pops and compares.
`timescale 1ns/1ps
module tb_cross_bar_arbiter_mux;

    localparam int MSEL = 2;
    localparam int CH   = 4;
    localparam int DW   = 32;

    logic          aclk   = 1'b0;
    logic          areset = 1'b1;
    logic [DW-1:0] s_tdata  [CH];
    logic          s_tvalid [CH];
    logic          s_tlast  [CH];
    logic          s_tready [CH];
    logic [CH-1:0] port_en;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, m_tready;
    logic [MSEL-1:0] grant_bin;
    logic          busy;

    always #5 aclk = ~aclk;

    cross_bar_arbiter_mux #(
        .MSEL_WIDTH (MSEL),
        .CHANNEL_NO (CH),
        .DATA_WIDTH (DW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .port_en       (port_en),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .grant_bin     (grant_bin),
        .busy          (busy)
    );

    logic [DW:0]  src_q [CH][$];   // pending input beats {last, data} per channel
    logic [DW:0]  sb_q  [$];       // expected output beats
    int unsigned  vprob [CH];
    int           rdy_mode;
    int unsigned  cyc;
    int           grant_log [$];
    int           n_checks = 0;
    int           n_fail   = 0;

    bit mdl_active = 1'b0;
    int mdl_rr     = 0;
    int mdl_grant  = 0;
    int mdl_cnt    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Input drivers and sink ready
    initial begin : driver
        bit hs [CH];
        cyc      = 0;
        m_tready = 1'b1;
        for (int i = 0; i < CH; i++) begin
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
            s_tdata[i]  = '0;
        end
        forever begin
            @(negedge aclk);
            for (int i = 0; i < CH; i++) hs[i] = s_tvalid[i] && s_tready[i];
            @(posedge aclk);
            #1;
            cyc++;
            for (int i = 0; i < CH; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0 && $urandom_range(99) < vprob[i]) begin
                    s_tvalid[i] = 1'b1;
                    {s_tlast[i], s_tdata[i]} = src_q[i][0];
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                    s_tdata[i]  = '0;
                end
            end
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = (cyc % 3 == 0);
                default: m_tready = 1'($urandom_range(1));
            endcase
        end
    end

    // Reference model: whole-packet grants, scan from pointer with wrap, 2-deep output buffer
    initial begin : model
        logic [CH-1:0] req;
        bit pop, push, nf, found;
        int w;
        wait (areset === 1'b1);
        @(posedge aclk);
        forever begin
            @(negedge aclk);
            #1;
            chk("busy", 64'(busy), 64'(mdl_active));
            chk("grant_bin", 64'(grant_bin), 64'(mdl_grant));
            chk("m_tvalid", 64'(m_tvalid), 64'(mdl_cnt > 0));
            pop = (mdl_cnt > 0) && m_tready;
            nf  = (mdl_cnt < 2) || pop;
            if (!areset) begin
                for (int i = 0; i < CH; i++)
                    chk($sformatf("s_tready%0d", i), 64'(s_tready[i]),
                        64'(mdl_active && mdl_grant == i && nf));
            end
            if (areset) begin
                mdl_active = 1'b0;
                mdl_rr     = 0;
                mdl_grant  = 0;
                mdl_cnt    = 0;
                sb_q.delete();
            end else begin
                push = 1'b0;
                if (!mdl_active) begin
                    for (int i = 0; i < CH; i++) req[i] = s_tvalid[i] && port_en[i];
                    found = 1'b0;
                    w     = 0;
                    for (int k = 0; k < CH; k++) begin
                        if (!found && req[(mdl_rr + k) % CH]) begin
                            found = 1'b1;
                            w     = (mdl_rr + k) % CH;
                        end
                    end
                    if (found) begin
                        mdl_active = 1'b1;
                        mdl_grant  = w;
                    end
                end else if (s_tvalid[mdl_grant] && nf) begin
                    push = 1'b1;
                    sb_q.push_back({s_tlast[mdl_grant], s_tdata[mdl_grant]});
                    if (s_tlast[mdl_grant]) begin
                        mdl_active = 1'b0;
                        mdl_rr     = (mdl_grant + 1) % CH;
                        mdl_grant  = 0;
                    end
                end
                mdl_cnt = mdl_cnt + int'(push) - int'(pop);
            end
        end
    end

    initial begin : monitor
        logic [DW:0] e;
        forever begin
            @(negedge aclk);
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected actual=%0h required=no beat t=%0t", m_tdata, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_data", 64'(m_tdata), 64'(e[DW-1:0]));
                    chk("out_last", 64'(m_tlast), 64'(e[DW]));
                end
            end
        end
    end

    initial begin : glog
        bit prev = 1'b0;
        forever begin
            @(negedge aclk);
            if (busy === 1'b1 && !prev) grant_log.push_back(int'(grant_bin));
            prev = (busy === 1'b1);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic send(input int ch, input int n, input logic [DW-1:0] base);
        for (int k = 0; k < n; k++) src_q[ch].push_back({(k == n - 1), base + DW'(k)});
    endtask

    function automatic bit pending();
        pending = (sb_q.size() != 0) || mdl_active;
        for (int i = 0; i < CH; i++) if (src_q[i].size() != 0) pending = 1'b1;
    endfunction

    task automatic drain(input string name);
        int t = 0;
        while (pending() && t < 3000) begin
            @(posedge aclk);
            t++;
        end
        chk({name, "_drain_timeout"}, 64'(t >= 3000), 64'd0);
        repeat (2) @(posedge aclk);
        #2;
    endtask

    task automatic wait_q(input int ch, input int sz, input string name);
        int t = 0;
        while (src_q[ch].size() > sz && t < 500) begin
            @(posedge aclk);
            #2;
            t++;
        end
        chk({name, "_wait_timeout"}, 64'(t >= 500), 64'd0);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #2;
        areset = 1'b0;
    endtask

    task automatic check_log(input string name, input int exp_g [8], input int n);
        chk({name, "_count"}, 64'(grant_log.size()), 64'(n));
        for (int i = 0; i < n; i++)
            if (i < grant_log.size())
                chk($sformatf("%s_grant%0d", name, i), 64'(grant_log[i]), 64'(exp_g[i]));
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_tdata"}, 64'(m_tdata), 64'd0);
        chk({name, "_tlast"}, 64'(m_tlast), 64'd0);
        chk({name, "_tvalid"}, 64'(m_tvalid), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_grant"}, 64'(grant_bin), 64'd0);
    endtask

    initial begin : main
        int exp_g [8];
        port_en  = '1;
        rdy_mode = 0;
        for (int i = 0; i < CH; i++) vprob[i] = 100;
        repeat (3) @(posedge aclk);
        #2;
        areset = 1'b0;
        check_idle_outputs("reset");

        // single 3-beat packet on input 2
        grant_log.delete();
        send(2, 3, 32'hA0);
        drain("single");
        exp_g = '{2, 0, 0, 0, 0, 0, 0, 0};
        check_log("single", exp_g, 1);

        // round robin with every input holding two 1-beat packets
        do_reset();
        grant_log.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < CH; c++) send(c, 1, 32'h100 * c + r);
        drain("rr");
        exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_log("rr", exp_g, 8);

        // backpressure: 8-beat packet on input 1 with sink ready 1,0,0,...
        rdy_mode = 1;
        send(1, 8, 32'hB0);
        drain("bp");
        rdy_mode = 0;

        // grant lock: input 0 stalls mid-packet while input 3 requests
        grant_log.delete();
        send(0, 4, 32'hC0);
        wait_q(0, 2, "lock");
        vprob[0] = 0;
        send(3, 2, 32'hD0);
        repeat (5) @(posedge aclk);
        #2;
        vprob[0] = 100;
        drain("lock");
        exp_g = '{0, 3, 0, 0, 0, 0, 0, 0};
        check_log("lock", exp_g, 2);

        // port_en mask 1010
        grant_log.delete();
        port_en = 4'b1010;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < CH; c++) send(c, 1, 32'h200 + 32'h10 * c + r);
        wait_q(1, 0, "mask1");
        wait_q(3, 0, "mask3");
        src_q[0].delete();
        src_q[2].delete();
        repeat (2) @(posedge aclk);
        #2;
        port_en = '1;
        drain("mask");
        exp_g = '{1, 3, 1, 3, 1, 3, 0, 0};
        check_log("mask", exp_g, 6);

        // reset in the middle of a 4-beat packet
        send(2, 4, 32'hE0);
        wait_q(2, 2, "midrst");
        areset = 1'b1;
        src_q[2].delete();
        @(posedge aclk);
        #2;
        check_idle_outputs("midrst");
        areset = 1'b0;
        grant_log.delete();
        send(0, 2, 32'hF0);
        send(1, 1, 32'hF8);
        drain("postrst");
        exp_g = '{0, 1, 0, 0, 0, 0, 0, 0};
        check_log("postrst", exp_g, 2);

        // randomized traffic, gaps, masks and sink stalls
        rdy_mode = 2;
        for (int p = 0; p < 40; p++)
            send(int'($urandom_range(CH - 1)), int'($urandom_range(6, 1)), $urandom);
        for (int i = 0; i < CH; i++) vprob[i] = $urandom_range(100, 30);
        for (int s = 0; s < 6; s++) begin
            port_en = CH'($urandom_range(15, 1));
            repeat (50) @(posedge aclk);
            #2;
        end
        port_en = '1;
        drain("rand");
        rdy_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
